// File: rtl/calc_key_entry_if.sv
// Keypad/arithmetic-side bundle for calc_key_entry: key strobes and arithmetic feedback
// in, operands, opcode, event pulses and display value out.
interface calc_key_entry_if #(
  parameter int MAG_W = 16
);
  logic             key_valid;
  logic [4:0]       key_code;
  logic [MAG_W:0]   answer;
  logic             ovw_in;
  logic [MAG_W:0]   V1;
  logic [MAG_W:0]   V2;
  logic [1:0]       opcode;
  logic             newop;
  logic             newhex;
  logic             eq;
  logic [MAG_W:0]   disp;

  modport master (
    output key_valid, key_code, answer, ovw_in,
    input  V1, V2, opcode, newop, newhex, eq, disp
  );

  modport slave (
    input  key_valid, key_code, answer, ovw_in,
    output V1, V2, opcode, newop, newhex, eq, disp
  );
endinterface

// File: rtl/calc_key_entry.sv
// Calculator key-entry front end: builds sign-magnitude operands from hex key strobes.
// Optional backspace on key 0x16 is built when CALC_BACKSPACE_EN is defined.
module calc_key_entry #(
  parameter int MAG_W  = 16,
  parameter int DIGITS = MAG_W / 4
) (
  input  logic              clock,
  input  logic              reset,
  calc_key_entry_if.slave   bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MUL  = 5'h11;
  localparam logic [4:0] KEY_SUB  = 5'h12;
  localparam logic [4:0] KEY_EQ   = 5'h13;
  localparam logic [4:0] KEY_CLR  = 5'h14;
  localparam logic [4:0] KEY_NEG  = 5'h15;
`ifdef CALC_BACKSPACE_EN
  localparam logic [4:0] KEY_BKSP = 5'h16;
`endif

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_OPWAIT = 2'd1,
    S_SECOND = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [MAG_W:0]   v1_q, v1_d;
  logic [MAG_W:0]   v2_q, v2_d;
  logic [1:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             newop_q, newop_d;
  logic             newhex_q, newhex_d;
  logic             eq_q, eq_d;
  logic [3:0]       digit;
  logic             entering;
  logic [MAG_W:0]   disp_w;

  assign digit    = bus.key_code[3:0];
  assign entering = (state_q == S_FIRST) || (state_q == S_SECOND);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned
  // and no latch is inferred; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d  = state_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    opcode_d = opcode_q;
    count_d  = count_q;
    newop_d  = 1'b0;
    newhex_d = 1'b0;
    eq_d     = 1'b0;

    if (bus.key_valid) begin
      if (!bus.key_code[4]) begin
        unique case (state_q)
          S_FIRST, S_SECOND: begin
            if (count_q < DIGITS_C) begin
              v1_d     = {v1_q[MAG_W], v1_q[MAG_W-5:0], digit};
              count_d  = count_q + CNT_W'(1);
              newhex_d = 1'b1;
            end
          end
          S_OPWAIT: begin
            v1_d     = {1'b0, MAG_W'(digit)};
            count_d  = CNT_W'(1);
            state_d  = S_SECOND;
            newhex_d = 1'b1;
          end
          S_RESULT: begin
            // A digit after equals starts a fresh calculation.
            v1_d     = {1'b0, MAG_W'(digit)};
            v2_d     = '0;
            opcode_d = 2'b00;
            count_d  = CNT_W'(1);
            state_d  = S_FIRST;
            newop_d  = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (bus.key_code)
          KEY_ADD, KEY_MUL, KEY_SUB: begin
            if (state_q == S_OPWAIT) begin
              opcode_d = bus.key_code[1:0];
              newop_d  = 1'b1;
            end else if (!(state_q == S_RESULT && bus.ovw_in)) begin
              // From SECOND/RESULT the running result becomes the new first operand.
              v2_d     = (state_q == S_FIRST) ? v1_q : bus.answer;
              v1_d     = '0;
              count_d  = '0;
              opcode_d = bus.key_code[1:0];
              state_d  = S_OPWAIT;
              newop_d  = 1'b1;
            end
          end
          KEY_EQ: begin
            if (state_q == S_FIRST) begin
              v2_d     = '0;
              opcode_d = 2'b00;
            end
            state_d = S_RESULT;
            eq_d    = 1'b1;
          end
          KEY_CLR: begin
            v1_d     = '0;
            v2_d     = '0;
            opcode_d = 2'b00;
            count_d  = '0;
            state_d  = S_FIRST;
            newop_d  = 1'b1;
          end
          KEY_NEG: begin
            if (entering) begin
              v1_d[MAG_W] = ~v1_q[MAG_W];
              newhex_d    = 1'b1;
            end else if (state_q == S_OPWAIT) begin
              v1_d     = {1'b1, {MAG_W{1'b0}}};
              state_d  = S_SECOND;
              newhex_d = 1'b1;
            end
          end
`ifdef CALC_BACKSPACE_EN
          KEY_BKSP: begin
            if (entering && count_q != '0) begin
              v1_d     = {v1_q[MAG_W], 4'h0, v1_q[MAG_W-1:4]};
              count_d  = count_q - CNT_W'(1);
              newhex_d = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FIRST;
      v1_q     <= '0;
      v2_q     <= '0;
      opcode_q <= 2'b00;
      count_q  <= '0;
      newop_q  <= 1'b0;
      newhex_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
      newop_q  <= newop_d;
      newhex_q <= newhex_d;
      eq_q     <= eq_d;
    end
  end

  always_comb begin
    disp_w = v1_q;
    unique case (state_q)
      S_FIRST, S_SECOND: disp_w = v1_q;
      S_OPWAIT:          disp_w = v2_q;
      S_RESULT:          disp_w = bus.ovw_in ? '0 : bus.answer;
      default:           disp_w = v1_q;
    endcase
  end

  assign bus.V1     = v1_q;
  assign bus.V2     = v2_q;
  assign bus.opcode = opcode_q;
  assign bus.newop  = newop_q;
  assign bus.newhex = newhex_q;
  assign bus.eq     = eq_q;
  assign bus.disp   = disp_w;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: key sequences with hand-computed operand,
// opcode, pulse and display expectations.
module tb_calc_key_entry;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   nh_count;

  calc_key_entry_if #(.MAG_W(16)) bus ();

  calc_key_entry #(.MAG_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe one key for one cycle; returns at the falling edge after the capturing edge.
  task automatic press(input logic [4:0] code);
    @(negedge clock);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clock);
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
  endtask

  task automatic pulses(input string tag, input logic op, input logic hx, input logic e);
    check({tag, ".newop"},  32'(bus.newop),  32'(op));
    check({tag, ".newhex"}, 32'(bus.newhex), 32'(hx));
    check({tag, ".eq"},     32'(bus.eq),     32'(e));
  endtask

  task automatic regs(input string tag, input logic [16:0] v1, input logic [16:0] v2,
                      input logic [1:0] op);
    check({tag, ".V1"},     32'(bus.V1),     32'(v1));
    check({tag, ".V2"},     32'(bus.V2),     32'(v2));
    check({tag, ".opcode"}, 32'(bus.opcode), 32'(op));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nh_count = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
    bus.answer    = '0;
    bus.ovw_in    = 1'b0;

    // Reset wins over a simultaneous key strobe.
    reset = 1'b1;
    @(negedge clock);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'h05;
    @(negedge clock);
    @(negedge clock);
    regs("rst", 17'h0, 17'h0, 2'b00);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    check("rst.disp", 32'(bus.disp), 32'h0);
    bus.key_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Five digits: only four fit.
    for (int i = 1; i <= 5; i++) begin
      press(5'(i));
      nh_count += int'(bus.newhex);
      check($sformatf("dig%0d.newhex", i), 32'(bus.newhex), (i <= 4) ? 32'd1 : 32'd0);
    end
    check("dig.V1", 32'(bus.V1), 32'h01234);
    check("dig.nh_total", 32'(nh_count), 32'd4);
    check("dig.disp", 32'(bus.disp), 32'h01234);
    @(negedge clock);
    pulses("idle", 1'b0, 1'b0, 1'b0);
    check("idle.V1", 32'(bus.V1), 32'h01234);

    // 7 + 5 = with the arithmetic unit returning 0xC.
    press(5'h14);
    pulses("clr", 1'b1, 1'b0, 1'b0);
    regs("clr", 17'h0, 17'h0, 2'b00);
    press(5'h07);
    press(5'h10);
    regs("add", 17'h0, 17'h7, 2'b00);
    pulses("add", 1'b1, 1'b0, 1'b0);
    check("add.disp", 32'(bus.disp), 32'h7);
    press(5'h05);
    pulses("d5", 1'b0, 1'b1, 1'b0);
    bus.answer = 17'h0000C;
    press(5'h13);
    pulses("eq", 1'b0, 1'b0, 1'b1);
    regs("eq", 17'h5, 17'h7, 2'b00);
    check("eq.disp", 32'(bus.disp), 32'h0000C);
    bus.ovw_in = 1'b1;
    #1;
    check("eq.disp_ovw", 32'(bus.disp), 32'h0);
    bus.ovw_in = 1'b0;
    press(5'h13);
    pulses("eq2", 1'b0, 1'b0, 1'b1);
    regs("eq2", 17'h5, 17'h7, 2'b00);

    // 3 * 4 - 2 : operator in SECOND chains the answer into V2.
    press(5'h14);
    press(5'h03);
    press(5'h11);
    pulses("mul", 1'b1, 1'b0, 1'b0);
    regs("mul", 17'h0, 17'h3, 2'b01);
    press(5'h04);
    bus.answer = 17'h0000C;
    press(5'h12);
    pulses("sub", 1'b1, 1'b0, 1'b0);
    regs("sub", 17'h0, 17'h0000C, 2'b10);
    press(5'h02);
    regs("chain", 17'h2, 17'h0000C, 2'b10);
    check("chain.disp", 32'(bus.disp), 32'h2);

    // Negate, eq from FIRST, ignored operator under overflow, then a fresh digit.
    press(5'h14);
    press(5'h05);
    press(5'h15);
    pulses("neg", 1'b0, 1'b1, 1'b0);
    check("neg.V1", 32'(bus.V1), 32'h10005);
    bus.answer = 17'h10005;
    press(5'h13);
    pulses("eqf", 1'b0, 1'b0, 1'b1);
    regs("eqf", 17'h10005, 17'h0, 2'b00);
    bus.ovw_in = 1'b1;
    press(5'h11);
    pulses("ovw_op", 1'b0, 1'b0, 1'b0);
    regs("ovw_op", 17'h10005, 17'h0, 2'b00);
    check("ovw_op.disp", 32'(bus.disp), 32'h0);
    bus.ovw_in = 1'b0;
    press(5'h15);
    pulses("neg_res", 1'b0, 1'b0, 1'b0);
    press(5'h09);
    pulses("d9", 1'b1, 1'b0, 1'b0);
    regs("d9", 17'h9, 17'h0, 2'b00);
    check("d9.disp", 32'(bus.disp), 32'h9);

    // Operator replacement and negate while waiting for the second operand.
    press(5'h14);
    press(5'h08);
    press(5'h10);
    press(5'h11);
    pulses("repl", 1'b1, 1'b0, 1'b0);
    regs("repl", 17'h0, 17'h8, 2'b01);
    press(5'h15);
    pulses("negw", 1'b0, 1'b1, 1'b0);
    check("negw.V1", 32'(bus.V1), 32'h10000);
    check("negw.disp", 32'(bus.disp), 32'h10000);
    press(5'h03);
    check("negw.dig", 32'(bus.V1), 32'h10003);

    // Eq straight from OPWAIT leaves V1 at zero.
    press(5'h14);
    press(5'h01);
    press(5'h12);
    bus.answer = 17'h00001;
    press(5'h13);
    pulses("eqw", 1'b0, 1'b0, 1'b1);
    regs("eqw", 17'h0, 17'h1, 2'b10);

    // Unused code and backspace.
    press(5'h14);
    press(5'h0A);
    press(5'h0B);
    press(5'h1F);
    pulses("unused", 1'b0, 1'b0, 1'b0);
    check("unused.V1", 32'(bus.V1), 32'h000AB);
    press(5'h16);
`ifdef CALC_BACKSPACE_EN
    pulses("bksp", 1'b0, 1'b1, 1'b0);
    check("bksp.V1", 32'(bus.V1), 32'h0000A);
    press(5'h0C);
    press(5'h0D);
    press(5'h0E);
    press(5'h0F);
    check("bksp.full_newhex", 32'(bus.newhex), 32'd0);
    check("bksp.refill", 32'(bus.V1), 32'h0ACDE);
`else
    pulses("bksp", 1'b0, 1'b0, 1'b0);
    check("bksp.V1", 32'(bus.V1), 32'h000AB);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
